tl_ul_initiator: RTL and testbench
==================================

Name: tl_ul_initiator

Overview:
- Single-outstanding TileLink-UL initiator that converts a simple core-side request/response port into A-channel Get/PutFullData/PutPartialData messages.
- Collects the matching D-channel AccessAck/AccessAckData and returns it on the response port.
- It is the requesting end of the tl_mem responder. It is used by bench agents and by non-core masters such as a DMA or debug port to reach memory over the same A/D channel signal set the core uses.

Parameters:
- AW, 32, address width
- DW, 128, data width; power of two, at least 64
- SRC_W, 3, source/sink field width
- SIZE_W, 8, size field width
- SOURCE_ID, 0, fixed value driven on a_source and expected on d_source
- TIMEOUT_CYC, 1024, watchdog limit in cycles (only with TL_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when valid&ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_data  in  DW  write data
- req_mask  in  DW/8  byte enables for writes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DW  read data; 0 for writes
- rsp_err  out  1  denied, corrupt, protocol or timeout error
- a_valid, a_ready  out, in  1  A-channel handshake
- a_opcode  out  3
- a_param  out  3
- a_size  out  SIZE_W
- a_source  out  SRC_W
- a_address  out  AW
- a_mask  out  DW/8
- a_data  out  DW
- a_corrupt  out  1
- d_valid, d_ready  in, out  1  D-channel handshake
- d_opcode  in  3
- d_param  in  2
- d_size  in  SIZE_W
- d_source  in  SRC_W
- d_sink  in  SRC_W
- d_denied  in  1
- d_data  in  DW
- d_corrupt  in  1
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (RSTn low, asynchronous) forces:
  - state IDLE
  - req_ready=1, a_valid=0, d_ready=0, rsp_valid=0, rsp_err=0
  - all A payload, rsp_data and busy = 0
- Reset mid-transaction abandons the transaction silently; no response is produced.
- FSM states are IDLE, A_SEND, D_WAIT, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request into A payload registers and go to A_SEND.
  - a_valid rises in the following cycle, so request acceptance to a_valid is 1 cycle.
- A payload encoding:
  - a_opcode = 4 (Get) for reads.
  - a_opcode = 0 (PutFullData) for writes with req_mask all ones; 1 (PutPartialData) for any other write mask.
  - a_param = 0, a_corrupt = 0, a_size = log2(DW/8) (4 at DW=128), a_source = SOURCE_ID.
  - a_address = req_addr with the low log2(DW/8) bits forced to 0.
  - a_mask = all ones for Get, req_mask for writes.
  - a_data = req_data for writes, 0 for Get.
- A_SEND:
  - a_valid is held with a stable payload until a_ready; the A handshake completes in that cycle.
  - Then go to D_WAIT; d_ready=1 from the next cycle.
- D_WAIT:
  - d_ready=1. On d_valid, capture the beat and go to RSP.
  - rsp_data = d_data when d_opcode = 1 (AccessAckData), else 0.
  - rsp_err is set if any of these hold:
    - d_denied or d_corrupt is high;
    - d_source differs from SOURCE_ID;
    - the opcode does not match the request (a read must get 1, a write must get 0).
  - d_param, d_size and d_sink are ignored.
- RSP:
  - rsp_valid=1 and stays high with a stable payload until rsp_ready.
  - The handshake cycle returns to IDLE with rsp_valid=0 next cycle.
- A D beat arriving in the same cycle as the A handshake is not accepted, because d_ready is still 0. The responder holds it.
- d_ready is 0 in IDLE, A_SEND and RSP.
- Minimum turnaround with zero-latency a_ready, responder and rsp_ready: request accept to rsp_valid is 3 cycles; back-to-back requests are possible every 4 cycles.
- Only one transaction is outstanding at any time.

Optional Feature:
- Macro: TL_TIMEOUT_EN.
- Defined:
  - A saturating counter clears on entry to D_WAIT and increments each D_WAIT cycle without d_valid.
  - On reaching TIMEOUT_CYC, go to RSP with rsp_err=1 and rsp_data=0, and set a sticky output tmo_flag (1 bit).
  - tmo_flag is cleared only by reset.
  - Any later D beat is not accepted.
- Undefined:
  - No counter and no tmo_flag port.
  - D_WAIT waits indefinitely.

Test Plan:
- Read req_addr=0x8000_001C with immediate a_ready and a tl_mem holding 0x0123..EF at line 0x8000_0010:
  - A-channel: a_opcode=4, a_address=0x8000_0010, a_size=4, a_mask=0xFFFF.
  - Response: rsp_data equals the line contents, rsp_err=0, rsp_valid 3 cycles after accept.
- Write with req_mask=0xFFFF, then a write with mask=0x00F0:
  - a_opcode=0, then a_opcode=1 with a_mask=0x00F0.
  - A read-back of the line shows only bytes 4..7 changed.
- a_ready held low for 5 cycles:
  - a_valid stays high and the payload stays stable; req_ready=0 throughout.
  - Exactly one A handshake occurs.
- D beat with d_denied=1, then one with d_source=SOURCE_ID+1: rsp_err=1 for each.
- rsp_ready held low for 4 cycles: rsp_valid and rsp_data stay stable; no new request is accepted.
- With TL_TIMEOUT_EN and TIMEOUT_CYC=16, responder never asserts d_valid:
  - rsp_valid arrives 16 cycles after the A handshake with rsp_err=1 and tmo_flag=1.
  - Drop RSTn mid-D_WAIT: all outputs return to reset values immediately.

Source files
------------

// File: rtl/tl_ul_initiator_if.sv
// Core request/response port plus TileLink-UL A/D channel signal set for one initiator.
// Latency: none, wires only.
// Backpressure: valid/ready on req, rsp, A and D; master = initiator side, slave = core/responder side.
interface tl_ul_initiator_if #(
    parameter int AW     = 32,
    parameter int DW     = 128,
    parameter int SRC_W  = 3,
    parameter int SIZE_W = 8
);
    // core-side request/response
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic [DW/8-1:0]   req_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    // A channel
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [AW-1:0]     a_address;
    logic [DW/8-1:0]   a_mask;
    logic [DW-1:0]     a_data;
    logic              a_corrupt;

    // D channel
    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [1:0]        d_param;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic [SRC_W-1:0]  d_sink;
    logic              d_denied;
    logic [DW-1:0]     d_data;
    logic              d_corrupt;

    modport master (
        input  req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_ul_initiator.sv
// Single-outstanding TileLink-UL initiator: core req -> A Get/PutFull/PutPartial, D ack -> core rsp.
// Latency: accept to rsp_valid 3 cycles minimum; one transaction every 4 cycles back-to-back.
// Backpressure: a_valid/rsp_valid held stable until ready; req_ready only in IDLE. Optional watchdog: TL_TIMEOUT_EN.
module tl_ul_initiator #(
    parameter int AW        = 32,
    parameter int DW        = 128,
    parameter int SRC_W     = 3,
    parameter int SIZE_W    = 8,
    parameter int SOURCE_ID = 0
`ifdef TL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic               CLK,
    input  logic               RSTn,
    tl_ul_initiator_if.master  bus,
    output logic               busy
`ifdef TL_TIMEOUT_EN
    ,
    output logic               tmo_flag
`endif
);
    localparam int MW    = DW / 8;
    localparam int OFF_W = $clog2(MW);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RSP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        a_opcode_q, a_opcode_d;
    logic [SIZE_W-1:0] a_size_q, a_size_d;
    logic [SRC_W-1:0]  a_source_q, a_source_d;
    logic [AW-1:0]     a_address_q, a_address_d;
    logic [MW-1:0]     a_mask_q, a_mask_d;
    logic [DW-1:0]     a_data_q, a_data_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              is_read;
    logic              d_bad;

`ifdef TL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic              tmo_hit;
`endif

    // Response attributes are deliberately ignored.
    logic unused_d_fields;
    assign unused_d_fields = ^{bus.d_param, bus.d_size, bus.d_sink};

    assign is_read = (a_opcode_q == OP_GET);
    assign d_bad   = bus.d_denied || bus.d_corrupt ||
                     (bus.d_source != SRC_W'(SOURCE_ID)) ||
                     (bus.d_opcode != (is_read ? OP_ACK_DATA : OP_ACK));
`ifdef TL_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt_q >= TMO_W'(TIMEOUT_CYC - 1));
`endif

    // Next-state and payload capture for the four-state transaction sequencer.
    always_comb begin
        state_d     = state_q;
        a_opcode_d  = a_opcode_q;
        a_size_d    = a_size_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef TL_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_flag_d  = tmo_flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = A_SEND;
                    a_opcode_d  = !bus.req_wr ? OP_GET :
                                  (&bus.req_mask) ? OP_PUT_FULL : OP_PUT_PART;
                    a_size_d    = SIZE_W'(OFF_W);
                    a_source_d  = SRC_W'(SOURCE_ID);
                    a_address_d = {bus.req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
                    a_mask_d    = bus.req_wr ? bus.req_mask : {MW{1'b1}};
                    a_data_d    = bus.req_wr ? bus.req_data : {DW{1'b0}};
                end
            end
            A_SEND: begin
                if (bus.a_ready) begin
                    state_d = D_WAIT;
`ifdef TL_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            D_WAIT: begin
                if (bus.d_valid) begin
                    state_d    = RSP;
                    rsp_data_d = (bus.d_opcode == OP_ACK_DATA) ? bus.d_data : {DW{1'b0}};
                    rsp_err_d  = d_bad;
                end
`ifdef TL_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Give up: report an error and never take a late beat.
                    state_d    = RSP;
                    rsp_data_d = {DW{1'b0}};
                    rsp_err_d  = 1'b1;
                    tmo_flag_d = 1'b1;
                    tmo_cnt_d  = TMO_W'(TIMEOUT_CYC);
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef TL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= a_size_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef TL_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flag_q  <= tmo_flag_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.a_valid   = (state_q == A_SEND);
    assign bus.d_ready   = (state_q == D_WAIT);
    assign bus.rsp_valid = (state_q == RSP);
    assign busy          = (state_q != IDLE);

    assign bus.a_opcode  = a_opcode_q;
    assign bus.a_param   = 3'd0;
    assign bus.a_size    = a_size_q;
    assign bus.a_source  = a_source_q;
    assign bus.a_address = a_address_q;
    assign bus.a_mask    = a_mask_q;
    assign bus.a_data    = a_data_q;
    assign bus.a_corrupt = 1'b0;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
`ifdef TL_TIMEOUT_EN
    assign tmo_flag      = tmo_flag_q;
`endif
endmodule

// File: tb/tb_tl_ul_initiator.sv
// Directed bench for tl_ul_initiator; the bench plays both the core and a one-line tl_mem responder.
// Latency: checks exact cycle positions of a_valid, d_ready and rsp_valid.
// Backpressure: stalls on a_ready and rsp_ready; timeout path when TL_TIMEOUT_EN is defined.
module tb_tl_ul_initiator;
    localparam int AW = 32, DW = 128, SRC_W = 3, SIZE_W = 8;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic busy;
`ifdef TL_TIMEOUT_EN
    logic tmo_flag;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] mem_line;

    tl_ul_initiator_if #(.AW(AW), .DW(DW), .SRC_W(SRC_W), .SIZE_W(SIZE_W)) bus ();

    tl_ul_initiator #(
        .AW(AW), .DW(DW), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .SOURCE_ID(0)
`ifdef TL_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .bus(bus),
        .busy(busy)
`ifdef TL_TIMEOUT_EN
        , .tmo_flag(tmo_flag)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full zero-latency transaction; the D beat is offered during the A handshake and must wait.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [127:0] wdata, input logic [15:0] wmask,
                        input logic [2:0] d_opc, input logic den, input logic cor,
                        input logic [2:0] src, input logic [2:0] exp_opc,
                        input logic [31:0] exp_addr, input logic [15:0] exp_mask,
                        input logic [127:0] exp_rdata, input logic exp_err);
        logic [127:0] bm;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_data  = wdata;
        bus.req_mask  = wmask;
        chk({tag, ".req_ready0"}, bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        chk({tag, ".a_valid"}, bus.a_valid, 1);
        chk({tag, ".a_opcode"}, bus.a_opcode, exp_opc);
        chk({tag, ".a_address"}, bus.a_address, exp_addr);
        chk({tag, ".a_mask"}, bus.a_mask, exp_mask);
        chk({tag, ".a_size"}, bus.a_size, 4);
        chk({tag, ".a_data"}, bus.a_data, wr ? wdata : 128'd0);
        chk({tag, ".a_param_src"}, {bus.a_param, bus.a_source, bus.a_corrupt}, 0);
        chk({tag, ".req_ready1"}, bus.req_ready, 0);
        chk({tag, ".busy1"}, busy, 1);
        bus.a_ready   = 1'b1;
        bus.d_valid   = 1'b1;
        bus.d_opcode  = d_opc;
        bus.d_data    = (d_opc == 3'd1) ? mem_line : 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;
        bus.d_denied  = den;
        bus.d_corrupt = cor;
        bus.d_source  = src;
        bus.d_param   = 2'd3;
        bus.d_sink    = 3'd5;
        bus.d_size    = 8'd4;
        chk({tag, ".d_ready_in_a"}, bus.d_ready, 0);
        // responder side of the A handshake: apply puts to the stored line
        for (int i = 0; i < 16; i++) bm[i*8 +: 8] = {8{bus.a_mask[i]}};
        if (bus.a_opcode != 3'd4) mem_line = (mem_line & ~bm) | (bus.a_data & bm);
        tick();
        bus.a_ready = 1'b0;
        chk({tag, ".a_valid_done"}, bus.a_valid, 0);
        chk({tag, ".d_ready"}, bus.d_ready, 1);
        chk({tag, ".rsp_early"}, bus.rsp_valid, 0);
        tick();
        bus.d_valid = 1'b0;
        chk({tag, ".rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, ".rsp_data"}, bus.rsp_data, exp_rdata);
        chk({tag, ".rsp_err"}, bus.rsp_err, exp_err);
        chk({tag, ".d_ready_rsp"}, bus.d_ready, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, bus.rsp_valid, 0);
        chk({tag, ".idle"}, {busy, bus.req_ready}, 2'b01);
    endtask

    initial begin
        int hs;
        int n;
        logic [127:0] line_now;
        bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_data = 0; bus.req_mask = 0;
        bus.rsp_ready = 0; bus.a_ready = 0;
        bus.d_valid = 0; bus.d_opcode = 0; bus.d_param = 0; bus.d_size = 0; bus.d_source = 0;
        bus.d_sink = 0; bus.d_denied = 0; bus.d_data = 0; bus.d_corrupt = 0;
        mem_line = 128'h0123456789ABCDEF_0123456789ABCDEF;

        // reset state
        tick();
        chk("rst.req_ready", bus.req_ready, 1);
        chk("rst.ctrl", {bus.a_valid, bus.d_ready, bus.rsp_valid, bus.rsp_err, busy}, 0);
        chk("rst.a_payload", {bus.a_opcode, bus.a_size, bus.a_source, bus.a_mask}, 0);
        chk("rst.a_address", bus.a_address, 0);
        chk("rst.a_data", bus.a_data, 0);
        chk("rst.rsp_data", bus.rsp_data, 0);
        RSTn = 1'b1;
        tick();

        xact("rd1", 0, 32'h8000_001C, 128'hFFFF, 16'h1234, 3'd1, 0, 0, 3'd0,
             3'd4, 32'h8000_0010, 16'hFFFF, 128'h0123456789ABCDEF_0123456789ABCDEF, 0);
        xact("wr_full", 1, 32'h8000_0010, {4{32'hA5A5_A5A5}}, 16'hFFFF, 3'd0, 0, 0, 3'd0,
             3'd0, 32'h8000_0010, 16'hFFFF, 128'd0, 0);
        xact("wr_part", 1, 32'h8000_0014, 128'h11112222_33334444_55556666_77778888, 16'h00F0,
             3'd0, 0, 0, 3'd0, 3'd1, 32'h8000_0010, 16'h00F0, 128'd0, 0);
        xact("rd_back", 0, 32'h8000_0010, 128'd0, 16'h0000, 3'd1, 0, 0, 3'd0,
             3'd4, 32'h8000_0010, 16'hFFFF, 128'hA5A5A5A5_A5A5A5A5_55556666_A5A5A5A5, 0);
        xact("denied", 0, 32'h8000_0010, 128'd0, 16'h0000, 3'd1, 1, 0, 3'd0,
             3'd4, 32'h8000_0010, 16'hFFFF, 128'hA5A5A5A5_A5A5A5A5_55556666_A5A5A5A5, 1);
        xact("bad_src", 0, 32'h8000_0010, 128'd0, 16'h0000, 3'd1, 0, 0, 3'd1,
             3'd4, 32'h8000_0010, 16'hFFFF, 128'hA5A5A5A5_A5A5A5A5_55556666_A5A5A5A5, 1);
        xact("corrupt", 1, 32'h8000_0010, 128'd0, 16'h0000, 3'd0, 0, 1, 3'd0,
             3'd1, 32'h8000_0010, 16'h0000, 128'd0, 1);
        xact("bad_opc", 0, 32'h8000_001F, 128'd0, 16'h0000, 3'd0, 0, 0, 3'd0,
             3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, 1);

        // a_ready stall then rsp_ready stall
        line_now = 128'hA5A5A5A5_A5A5A5A5_55556666_A5A5A5A5;
        hs = 0;
        bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = 32'h8000_0018;
        tick();
        bus.req_addr = 32'h9000_0000;
        for (int i = 0; i < 5; i++) begin
            chk("stall.a_valid", bus.a_valid, 1);
            chk("stall.a_address", bus.a_address, 32'h8000_0010);
            chk("stall.a_opcode", bus.a_opcode, 4);
            chk("stall.req_ready", bus.req_ready, 0);
            if (bus.a_valid && bus.a_ready) hs++;
            tick();
        end
        bus.req_valid = 0;
        bus.a_ready = 1;
        if (bus.a_valid && bus.a_ready) hs++;
        tick();
        bus.a_ready = 1;
        if (bus.a_valid && bus.a_ready) hs++;
        bus.a_ready = 0;
        chk("stall.one_hs", hs, 1);
        bus.d_valid = 1; bus.d_opcode = 3'd1; bus.d_data = mem_line;
        bus.d_denied = 0; bus.d_corrupt = 0; bus.d_source = 0;
        tick();
        bus.d_valid = 0;
        bus.req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            chk("rstall.rsp_valid", bus.rsp_valid, 1);
            chk("rstall.rsp_data", bus.rsp_data, line_now);
            chk("rstall.req_ready", bus.req_ready, 0);
            tick();
        end
        bus.req_valid = 0;
        bus.rsp_ready = 1;
        chk("rstall.last", bus.rsp_valid, 1);
        tick();
        bus.rsp_ready = 0;
        chk("rstall.done", {bus.rsp_valid, busy}, 0);

`ifdef TL_TIMEOUT_EN
        // responder never answers
        bus.req_valid = 1; bus.req_addr = 32'h8000_0010;
        tick();
        bus.req_valid = 0;
        bus.a_ready = 1;
        tick();
        bus.a_ready = 0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("tmo.cycles", n, 16);
        chk("tmo.rsp_err", bus.rsp_err, 1);
        chk("tmo.rsp_data", bus.rsp_data, 0);
        chk("tmo.flag", tmo_flag, 1);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        bus.req_valid = 1;
        tick();
        bus.req_valid = 0;
        bus.a_ready = 1;
        tick();
        bus.a_ready = 0;
        tick();
        chk("tmo.in_dwait", bus.d_ready, 1);
        RSTn = 0;
        #1;
        chk("tmo.rst_ctrl", {bus.req_ready, bus.a_valid, bus.d_ready, bus.rsp_valid, busy}, 5'b10000);
        chk("tmo.rst_flag", tmo_flag, 0);
        chk("tmo.rst_payload", {bus.a_opcode, bus.a_address, bus.rsp_err}, 0);
        tick();
        RSTn = 1;
        tick();
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
